nec_ir_rcv: RTL and testbench
=============================

Name: nec_ir_rcv

Overview:
Parametrised NEC infrared receiver and successor to remote_rcv. Decodes the full 32-bit NEC frame: 16-bit address (standard or extended), 8-bit command with inverse check, repeat codes, and classified error reporting. Timing is derived from CLK_FREQ, so the block runs at any system clock. Sits between the IR demodulator pin (active-low bursts) and the key/command logic.

Parameters:
CLK_FREQ, 50_000_000, sys_clk frequency in Hz; the microsecond tick divider is CLK_FREQ/1_000_000.
TOL_PCT, 20, accepted pulse-width tolerance, ± percent of nominal.
EXT_ADDR, 0, 0 = address byte plus checked inverse (addr[15:8]=0); 1 = 16-bit extended address, no address check.
FILT_CYC, 8, glitch-filter stability length in sys_clk cycles (used only with IR_GLITCH_FILTER_EN).

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous reset, active low
remote_in  in  1  raw IR input, idle high, burst = low
frame_valid  out  1  one-cycle pulse: new frame decoded and checked
repeat_en  out  1  one-cycle pulse: valid repeat code
addr  out  16  last good address
data  out  8  last good command
err  out  1  one-cycle pulse: frame or repeat rejected
err_code  out  2  error class, valid with err: 1 = timing, 2 = check fail, 3 = orphan repeat

Behaviour:
- One clock domain (sys_clk). Reset is asynchronous, active low, on sys_rst_n. Reset values: all outputs 0, FSM in IDLE, repeat-armed flag cleared.
- Input path: 2-FF synchroniser, then a registered edge detector. A 1 µs tick prescaler drives a 16-bit pulse-width counter that saturates at 0xFFFF and clears on every detected edge.
- Windows: nominal N ± N*TOL_PCT/100, computed at elaboration with integer math.
- Nominal widths in µs: lead low 9000, lead high 4500 (frame) or 2250 (repeat), bit low 560, bit high 560 for 0 and 1690 for 1, stop burst 560.
- FSM states and transitions:
  - IDLE: falling edge -> LEAD_L.
  - LEAD_L: at the rising edge, width in the 9000 window -> LEAD_H, else ERR(1).
  - LEAD_H: at the falling edge, width in the 4500 window -> BIT_L (bit index 0); in the 2250 window -> REP_STOP; else ERR(1).
  - BIT_L: at the rising edge, width in the 560 window -> BIT_H, else ERR(1).
  - BIT_H: at the falling edge, the 560 window shifts in 0 and the 1690 window shifts in 1, LSB first. Index 31 -> STOP, else BIT_L. Any other width -> ERR(1).
  - STOP: at the rising edge with width in the 560 window, run the checks.
    - Checks: byte2 == ~byte3, and byte0 == ~byte1 when EXT_ADDR=0.
    - Pass: update addr/data, pulse frame_valid, set the armed flag, go to IDLE.
    - Fail: ERR(2); addr/data hold their values.
  - REP_STOP: at the rising edge with the 560 window: armed -> pulse repeat_en; not armed -> ERR(3). Then IDLE.
  - ERR(c): pulse err with err_code=c for one cycle, clear the armed flag, go to IDLE.
- Timeout: in any non-IDLE state, the counter exceeding the current window max without an edge -> ERR(1). The line then stays high and IDLE waits for a falling edge.
- addr assembly: EXT_ADDR=0 gives {8'h00, byte0}; EXT_ADDR=1 gives {byte1, byte0}.
- Latency: frame_valid, repeat_en and err are asserted at most 4 sys_clk cycles after the qualifying remote_in edge. The three pulses are mutually exclusive in any cycle.
- Reset mid-frame: the frame is abandoned with no err pulse. Outputs and armed flag return to 0.

Optional Feature:
IR_GLITCH_FILTER_EN
- Defined: after the synchroniser, the line changes state only when the new level has been stable for FILT_CYC consecutive cycles. Pulses shorter than FILT_CYC are ignored, and latency grows by FILT_CYC cycles.
- Undefined: synchroniser only; every synchronised edge is used.

Test Plan:
1. 50 MHz, EXT_ADDR=0. Send frame bytes 0x00, 0xFF, 0x45, 0xBA (LSB first) plus stop burst -> one frame_valid pulse, addr=0x0000, data=0x45, err stays 0.
2. After test 1, send 9000 low / 2250 high / 560 low -> one repeat_en pulse; addr/data unchanged.
3. After reset, send a repeat code only -> err pulse with err_code=3, no repeat_en.
4. Send bytes 0x00, 0xFF, 0x45, 0xBB -> err pulse with err_code=2, no frame_valid, data holds its prior value.
5. Hold remote_in low for 20 ms -> err pulse with err_code=1 about 10.8 ms after the falling edge. A following good frame then decodes normally.
6. EXT_ADDR=1, bytes 0x12, 0x34, 0x08, 0xF7 -> addr=0x3412, data=0x08. Assert sys_rst_n=0 at bit 10 of a second frame -> all outputs 0, no pulses.

Source files
------------

// File: rtl/nec_ir_rcv.sv
// NEC IR receiver: 32-bit frames, repeat codes and classified errors, timing derived from CLK_FREQ.
// Optional glitch filter enabled by defining IR_GLITCH_FILTER_EN; TIME_DIV scales all nominal widths (1 for real IR).
//
//   state      | meaning
//   S_IDLE     | line idle, waiting for a falling edge
//   S_LEAD_L   | measuring the 9 ms leader burst
//   S_LEAD_H   | measuring leader space: 4.5 ms frame or 2.25 ms repeat
//   S_BIT_L    | measuring a 560 us bit burst
//   S_BIT_H    | measuring bit space, shifts the bit in LSB first
//   S_STOP     | measuring the stop burst of a frame, then checks
//   S_REP_STOP | measuring the stop burst of a repeat code
`timescale 1ns/1ps
module nec_ir_rcv #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int TOL_PCT  = 20,
    parameter int EXT_ADDR = 0,
    parameter int FILT_CYC = 8,
    parameter int TIME_DIV = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        remote_in,
    output logic        frame_valid,
    output logic        repeat_en,
    output logic [15:0] addr,
    output logic [7:0]  data,
    output logic        err,
    output logic [1:0]  err_code
);

    function automatic logic [15:0] win_lo(input int nom);
        return 16'(nom - (nom * TOL_PCT) / 100);
    endfunction

    function automatic logic [15:0] win_hi(input int nom);
        return 16'(nom + (nom * TOL_PCT) / 100);
    endfunction

    function automatic logic in_win(input logic [15:0] w, input logic [15:0] lo,
                                    input logic [15:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LEAD_L   = 3'd1;
    localparam logic [2:0] S_LEAD_H   = 3'd2;
    localparam logic [2:0] S_BIT_L    = 3'd3;
    localparam logic [2:0] S_BIT_H    = 3'd4;
    localparam logic [2:0] S_STOP     = 3'd5;
    localparam logic [2:0] S_REP_STOP = 3'd6;

    localparam logic [1:0] E_TIMING = 2'd1;
    localparam logic [1:0] E_CHECK  = 2'd2;
    localparam logic [1:0] E_ORPHAN = 2'd3;

    localparam int DIV = (CLK_FREQ / 1_000_000 < 1) ? 1 : CLK_FREQ / 1_000_000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam int N_LL = 9000 / TIME_DIV;
    localparam int N_LH = 4500 / TIME_DIV;
    localparam int N_RH = 2250 / TIME_DIV;
    localparam int N_B  = 560 / TIME_DIV;
    localparam int N_B1 = 1690 / TIME_DIV;

    localparam logic [15:0] LL_LO = win_lo(N_LL);
    localparam logic [15:0] LL_HI = win_hi(N_LL);
    localparam logic [15:0] LH_LO = win_lo(N_LH);
    localparam logic [15:0] LH_HI = win_hi(N_LH);
    localparam logic [15:0] RH_LO = win_lo(N_RH);
    localparam logic [15:0] RH_HI = win_hi(N_RH);
    localparam logic [15:0] B_LO  = win_lo(N_B);
    localparam logic [15:0] B_HI  = win_hi(N_B);
    localparam logic [15:0] B1_LO = win_lo(N_B1);
    localparam logic [15:0] B1_HI = win_hi(N_B1);

    logic          sync1, sync2, line, line_q;
    logic          rise_q, fall_q, edge_q;
    logic [PW-1:0] pre;
    logic          tick;
    logic [15:0]   width;
    logic [2:0]    state, nxt;
    logic [4:0]    idx;
    logic [31:0]   sr;
    logic          armed;

    logic          e_err, e_frame, e_rep, sh_en, sh_bit, idx_clr;
    logic [1:0]    e_code;
    logic [15:0]   tmax;
    logic          chk_ok;
    logic [15:0]   addr_new;

    // Synchroniser resets to the idle-high level so reset release never looks like an edge
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= remote_in;
            sync2 <= sync1;
        end
    end

`ifdef IR_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILT_CYC + 1);
    logic [FW-1:0] fcnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            line <= 1'b1;
            fcnt <= '0;
        end else if (sync2 == line) begin
            fcnt <= '0;
        end else if (fcnt == FW'(FILT_CYC - 1)) begin
            line <= sync2;
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + FW'(1);
        end
    end
`else
    assign line = sync2;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            line_q <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            line_q <= line;
            rise_q <= line & ~line_q;
            fall_q <= ~line & line_q;
        end
    end

    assign edge_q = rise_q | fall_q;
    assign tick   = (pre == PW'(DIV - 1));

    // Width is measured in microsecond ticks since the last edge
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pre   <= '0;
            width <= '0;
        end else if (edge_q) begin
            pre   <= '0;
            width <= '0;
        end else begin
            pre <= tick ? '0 : pre + PW'(1);
            if (tick && width != 16'hFFFF)
                width <= width + 16'd1;
        end
    end

    assign chk_ok   = (sr[23:16] == ~sr[31:24]) &&
                      ((EXT_ADDR != 0) || (sr[7:0] == ~sr[15:8]));
    assign addr_new = (EXT_ADDR != 0) ? sr[15:0] : {8'h00, sr[7:0]};

    always_comb begin
        case (state)
            S_LEAD_L: tmax = LL_HI;
            S_LEAD_H: tmax = LH_HI;
            S_BIT_H:  tmax = B1_HI;
            default:  tmax = B_HI;
        endcase
    end

    always_comb begin
        nxt     = state;
        e_err   = 1'b0;
        e_code  = 2'd0;
        e_frame = 1'b0;
        e_rep   = 1'b0;
        sh_en   = 1'b0;
        sh_bit  = 1'b0;
        idx_clr = 1'b0;
        case (state)
            S_IDLE: if (fall_q) nxt = S_LEAD_L;
            S_LEAD_L: if (rise_q) begin
                if (in_win(width, LL_LO, LL_HI)) nxt = S_LEAD_H;
                else begin e_err = 1'b1; e_code = E_TIMING; end
            end
            S_LEAD_H: if (fall_q) begin
                if (in_win(width, LH_LO, LH_HI)) begin
                    nxt     = S_BIT_L;
                    idx_clr = 1'b1;
                end else if (in_win(width, RH_LO, RH_HI)) begin
                    nxt = S_REP_STOP;
                end else begin
                    e_err = 1'b1; e_code = E_TIMING;
                end
            end
            S_BIT_L: if (rise_q) begin
                if (in_win(width, B_LO, B_HI)) nxt = S_BIT_H;
                else begin e_err = 1'b1; e_code = E_TIMING; end
            end
            S_BIT_H: if (fall_q) begin
                if (in_win(width, B_LO, B_HI)) begin
                    sh_en = 1'b1;
                end else if (in_win(width, B1_LO, B1_HI)) begin
                    sh_en  = 1'b1;
                    sh_bit = 1'b1;
                end else begin
                    e_err = 1'b1; e_code = E_TIMING;
                end
                if (sh_en) nxt = (idx == 5'd31) ? S_STOP : S_BIT_L;
            end
            S_STOP: if (rise_q) begin
                if (!in_win(width, B_LO, B_HI)) begin
                    e_err = 1'b1; e_code = E_TIMING;
                end else if (chk_ok) begin
                    e_frame = 1'b1;
                    nxt     = S_IDLE;
                end else begin
                    e_err = 1'b1; e_code = E_CHECK;
                end
            end
            S_REP_STOP: if (rise_q) begin
                if (!in_win(width, B_LO, B_HI)) begin
                    e_err = 1'b1; e_code = E_TIMING;
                end else if (armed) begin
                    e_rep = 1'b1;
                    nxt   = S_IDLE;
                end else begin
                    e_err = 1'b1; e_code = E_ORPHAN;
                end
            end
            default: nxt = S_IDLE;
        endcase
        // A stuck line in any active state ends the frame as a timing error
        if (state != S_IDLE && !edge_q && width > tmax) begin
            e_err  = 1'b1;
            e_code = E_TIMING;
        end
        if (e_err) nxt = S_IDLE;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            sr          <= '0;
            armed       <= 1'b0;
            frame_valid <= 1'b0;
            repeat_en   <= 1'b0;
            err         <= 1'b0;
            err_code    <= 2'd0;
            addr        <= '0;
            data        <= '0;
        end else begin
            state       <= nxt;
            frame_valid <= e_frame;
            repeat_en   <= e_rep;
            err         <= e_err;
            if (idx_clr)
                idx <= '0;
            else if (sh_en)
                idx <= idx + 5'd1;
            if (sh_en)
                sr <= {sh_bit, sr[31:1]};
            if (e_err) begin
                err_code <= e_code;
                armed    <= 1'b0;
            end else if (e_frame) begin
                armed <= 1'b1;
                addr  <= addr_new;
                data  <= sr[23:16];
            end
        end
    end

endmodule

// File: tb/tb_nec_ir_rcv.sv
// Directed bench for nec_ir_rcv: standard and extended-address instances share one IR line.
// Runs at 2 MHz with widths scaled by 20 so whole frames fit in a short run.
`timescale 1ns/1ps
module tb_nec_ir_rcv;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        remote_in = 1'b1;

    logic        fv_s, rep_s, err_s, fv_e, rep_e, err_e;
    logic [15:0] addr_s, addr_e;
    logic [7:0]  data_s, data_e;
    logic [1:0]  code_s, code_e;

    int total = 0;
    int bad = 0;

    int cyc = 0;
    int n_fv_s = 0, n_rep_s = 0, n_err_s = 0;
    int n_fv_e = 0, n_rep_e = 0, n_err_e = 0;
    int n_ovl = 0;
    int last_err_cyc_s = 0;
    logic [1:0] last_code_s = 2'd0;

    int b_fv_s, b_rep_s, b_err_s, b_fv_e, b_rep_e, b_err_e;

    always #250 sys_clk = ~sys_clk;

    nec_ir_rcv #(.CLK_FREQ(2_000_000), .TOL_PCT(20), .EXT_ADDR(0), .FILT_CYC(8), .TIME_DIV(20)) u_std (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .remote_in(remote_in),
        .frame_valid(fv_s), .repeat_en(rep_s), .addr(addr_s), .data(data_s),
        .err(err_s), .err_code(code_s));

    nec_ir_rcv #(.CLK_FREQ(2_000_000), .TOL_PCT(20), .EXT_ADDR(1), .FILT_CYC(8), .TIME_DIV(20)) u_ext (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .remote_in(remote_in),
        .frame_valid(fv_e), .repeat_en(rep_e), .addr(addr_e), .data(data_e),
        .err(err_e), .err_code(code_e));

    always @(negedge sys_clk) begin
        cyc = cyc + 1;
        if (fv_s)  n_fv_s  = n_fv_s + 1;
        if (rep_s) n_rep_s = n_rep_s + 1;
        if (err_s) begin
            n_err_s = n_err_s + 1;
            last_code_s = code_s;
            last_err_cyc_s = cyc;
        end
        if (fv_e)  n_fv_e  = n_fv_e + 1;
        if (rep_e) n_rep_e = n_rep_e + 1;
        if (err_e) n_err_e = n_err_e + 1;
        if (int'(fv_s) + int'(rep_s) + int'(err_s) > 1) n_ovl = n_ovl + 1;
        if (int'(fv_e) + int'(rep_e) + int'(err_e) > 1) n_ovl = n_ovl + 1;
    end

    task automatic snap();
        b_fv_s = n_fv_s; b_rep_s = n_rep_s; b_err_s = n_err_s;
        b_fv_e = n_fv_e; b_rep_e = n_rep_e; b_err_e = n_err_e;
    endtask

    // Level held for a number of scaled microseconds (2 clocks each)
    task automatic hold(input logic lvl, input int us);
        @(posedge sys_clk); #1;
        remote_in = lvl;
        repeat (us * 2 - 1) @(posedge sys_clk);
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input int nbits);
        logic [31:0] w;
        w = {b3, b2, b1, b0};
        hold(1'b0, 450);
        hold(1'b1, 225);
        for (int i = 0; i < nbits; i++) begin
            hold(1'b0, 28);
            hold(1'b1, w[i] ? 84 : 28);
        end
        if (nbits == 32) begin
            hold(1'b0, 28);
            hold(1'b1, 200);
        end
    endtask

    task automatic send_repeat();
        hold(1'b0, 450);
        hold(1'b1, 112);
        hold(1'b0, 28);
        hold(1'b1, 200);
    endtask

    task automatic pulse_reset();
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b0;
        repeat (5) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        repeat (10) @(posedge sys_clk);
    endtask

    task automatic test_reset();
        remote_in = 1'b1;
        sys_rst_n = 1'b0;
        repeat (5) @(posedge sys_clk);
        @(negedge sys_clk);
        total++;
        if ({fv_s, rep_s, err_s, code_s, addr_s, data_s} !== 29'd0) begin
            bad++; $display("FAIL reset_std: got %h required 0", {fv_s, rep_s, err_s, code_s, addr_s, data_s});
        end
        total++;
        if ({fv_e, rep_e, err_e, code_e, addr_e, data_e} !== 29'd0) begin
            bad++; $display("FAIL reset_ext: got %h required 0", {fv_e, rep_e, err_e, code_e, addr_e, data_e});
        end
        #1 sys_rst_n = 1'b1;
        repeat (20) @(posedge sys_clk);
        @(negedge sys_clk);
        total++;
        if ({fv_s, rep_s, err_s, addr_s, data_s} !== 27'd0 || n_err_s != 0) begin
            bad++; $display("FAIL reset_release: got %h errs %0d required 0", {fv_s, rep_s, err_s, addr_s, data_s}, n_err_s);
        end
    endtask

    task automatic test_frame();
        snap();
        send_frame(8'h00, 8'hFF, 8'h45, 8'hBA, 32);
        total++;
        if (n_fv_s - b_fv_s != 1) begin
            bad++; $display("FAIL frame_valid_count: got %0d required 1", n_fv_s - b_fv_s);
        end
        total++;
        if (n_err_s - b_err_s != 0) begin
            bad++; $display("FAIL frame_err_count: got %0d required 0", n_err_s - b_err_s);
        end
        total++;
        if (addr_s !== 16'h0000 || data_s !== 8'h45) begin
            bad++; $display("FAIL frame_addr_data: got %h/%h required 0000/45", addr_s, data_s);
        end
    endtask

    task automatic test_repeat();
        snap();
        send_repeat();
        total++;
        if (n_rep_s - b_rep_s != 1 || n_err_s - b_err_s != 0 || n_fv_s - b_fv_s != 0) begin
            bad++; $display("FAIL repeat_pulses: got rep %0d err %0d fv %0d required 1 0 0",
                            n_rep_s - b_rep_s, n_err_s - b_err_s, n_fv_s - b_fv_s);
        end
        total++;
        if (addr_s !== 16'h0000 || data_s !== 8'h45) begin
            bad++; $display("FAIL repeat_hold: got %h/%h required 0000/45", addr_s, data_s);
        end
    endtask

    task automatic test_bad_check();
        snap();
        send_frame(8'h00, 8'hFF, 8'h45, 8'hBB, 32);
        total++;
        if (n_err_s - b_err_s != 1 || last_code_s !== 2'd2) begin
            bad++; $display("FAIL check_err: got count %0d code %0d required 1 code 2", n_err_s - b_err_s, last_code_s);
        end
        total++;
        if (n_fv_s - b_fv_s != 0 || data_s !== 8'h45) begin
            bad++; $display("FAIL check_hold: got fv %0d data %h required 0 45", n_fv_s - b_fv_s, data_s);
        end
    endtask

    task automatic test_repeat_after_error();
        snap();
        send_repeat();
        total++;
        if (n_err_s - b_err_s != 1 || last_code_s !== 2'd3 || n_rep_s - b_rep_s != 0) begin
            bad++; $display("FAIL disarmed_repeat: got err %0d code %0d rep %0d required 1 3 0",
                            n_err_s - b_err_s, last_code_s, n_rep_s - b_rep_s);
        end
    endtask

    task automatic test_orphan_repeat();
        pulse_reset();
        snap();
        send_repeat();
        total++;
        if (n_err_s - b_err_s != 1 || last_code_s !== 2'd3 || n_rep_s - b_rep_s != 0) begin
            bad++; $display("FAIL orphan_repeat: got err %0d code %0d rep %0d required 1 3 0",
                            n_err_s - b_err_s, last_code_s, n_rep_s - b_rep_s);
        end
        total++;
        if (data_s !== 8'h00 || addr_s !== 16'h0000) begin
            bad++; $display("FAIL orphan_data: got %h/%h required 0000/00", addr_s, data_s);
        end
    endtask

    task automatic test_bad_lead();
        snap();
        hold(1'b0, 300);
        hold(1'b1, 300);
        total++;
        if (n_err_s - b_err_s != 1 || last_code_s !== 2'd1) begin
            bad++; $display("FAIL short_lead: got err %0d code %0d required 1 code 1", n_err_s - b_err_s, last_code_s);
        end
    endtask

    task automatic test_timeout();
        int start;
        int lat;
        snap();
        @(posedge sys_clk); #1;
        start = cyc;
        remote_in = 1'b0;
        repeat (2000) @(posedge sys_clk);
        #1 remote_in = 1'b1;
        repeat (400) @(posedge sys_clk);
        lat = last_err_cyc_s - start;
        total++;
        if (n_err_s - b_err_s != 1 || last_code_s !== 2'd1) begin
            bad++; $display("FAIL timeout_err: got count %0d code %0d required 1 code 1", n_err_s - b_err_s, last_code_s);
        end
        total++;
        if (lat < 1070 || lat > 1100) begin
            bad++; $display("FAIL timeout_latency: got %0d cycles required 1070..1100", lat);
        end
    endtask

    task automatic test_after_timeout();
        snap();
        send_frame(8'h00, 8'hFF, 8'h16, 8'hE9, 32);
        total++;
        if (n_fv_s - b_fv_s != 1 || n_err_s - b_err_s != 0 || data_s !== 8'h16) begin
            bad++; $display("FAIL recover_frame: got fv %0d err %0d data %h required 1 0 16",
                            n_fv_s - b_fv_s, n_err_s - b_err_s, data_s);
        end
    endtask

    task automatic test_ext_addr();
        snap();
        send_frame(8'h12, 8'h34, 8'h08, 8'hF7, 32);
        total++;
        if (n_fv_e - b_fv_e != 1 || addr_e !== 16'h3412 || data_e !== 8'h08) begin
            bad++; $display("FAIL ext_frame: got fv %0d addr %h data %h required 1 3412 08",
                            n_fv_e - b_fv_e, addr_e, data_e);
        end
        total++;
        if (n_err_s - b_err_s != 1 || last_code_s !== 2'd2 || data_s !== 8'h16) begin
            bad++; $display("FAIL std_addr_check: got err %0d code %0d data %h required 1 2 16",
                            n_err_s - b_err_s, last_code_s, data_s);
        end
    endtask

    task automatic test_reset_mid_frame();
        snap();
        send_frame(8'h12, 8'h34, 8'h08, 8'hF7, 10);
        hold(1'b0, 10);
        #1 sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        total++;
        if ({fv_e, rep_e, err_e, code_e, addr_e, data_e} !== 29'd0) begin
            bad++; $display("FAIL midreset_outputs: got %h required 0", {fv_e, rep_e, err_e, code_e, addr_e, data_e});
        end
        remote_in = 1'b1;
        repeat (20) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        repeat (400) @(posedge sys_clk);
        total++;
        if (n_fv_e - b_fv_e != 0 || n_rep_e - b_rep_e != 0 || n_err_e - b_err_e != 0 ||
            n_fv_s - b_fv_s != 0 || n_err_s - b_err_s != 0 || addr_e !== 16'h0000 || data_s !== 8'h00) begin
            bad++; $display("FAIL midreset_quiet: got fv %0d rep %0d err %0d/%0d addr %h required none and 0000",
                            n_fv_e - b_fv_e, n_rep_e - b_rep_e, n_err_e - b_err_e, n_err_s - b_err_s, addr_e);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_repeat();
        test_bad_check();
        test_repeat_after_error();
        test_orphan_repeat();
        test_bad_lead();
        test_timeout();
        test_after_timeout();
        test_ext_addr();
        test_reset_mid_frame();
        total++;
        if (n_ovl != 0) begin
            bad++; $display("FAIL pulse_exclusive: got %0d overlapping cycles required 0", n_ovl);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
